ddr_game_ctrl: RTL and testbench

Game sequencer for the dance-arrow game. Spawns arrows into four lanes from an LFSR on a frame-based beat and advances their vertical positions once per frame. Judges debounced button presses against a hit window and maintains score and miss counts. Drives lane state to the graphic renderer and the binary score to the BCD/7-seg path, and runs the IDLE/PLAY/OVER round FSM.

---
 rtl/ddr_game_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ddr_game_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_game_ctrl.sv
// ddr_game_ctrl: round sequencer for the dance-arrow game.
// Spawns arrows into four lanes from an 8-bit LFSR every SPAWN_DIV frame
// ticks, drops them SPEED pixels per tick, judges button presses against the
// target window and keeps saturating score/miss counters.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   frame_tick          one-cycle pulse per video frame
//   start               one-cycle pulse (centre button)
//   btn_u/d/l/r         debounced button levels (lanes 0..3)
//   lane_active[3:0]    arrow present per lane
//   lane_y[43:0]        lane k y-position at [11k+10:11k]
//   score[15:0]         binary score, saturates at MAX_SCORE
//   misses[3:0]         miss count, saturates at MISS_LIMIT
//   state[1:0]          0=IDLE 1=PLAY 2=OVER
//   game_over           high while in OVER

// Per-lane next-state logic: judge, fall/expire, spawn.
module ddr_lane #(
    parameter int SPEED   = 2,
    parameter int HIT_Y   = 400,
    parameter int HIT_WIN = 16
) (
    input  logic        active_q,
    input  logic [10:0] y_q,
    input  logic        press,
    input  logic        tick,
    input  logic        spawn,
    output logic        active_d,
    output logic [10:0] y_d,
    output logic        hit,
    output logic [1:0]  miss_cnt
);
    localparam logic [11:0] WIN_LO = 12'(HIT_Y - HIT_WIN);
    localparam logic [11:0] WIN_HI = 12'(HIT_Y + HIT_WIN);

    logic [11:0] y_ext;
    logic [11:0] y_fall;
    logic        in_win;

    assign y_ext  = {1'b0, y_q};
    assign y_fall = y_ext + 12'(SPEED);
    assign in_win = active_q && (y_ext >= WIN_LO) && (y_ext <= WIN_HI);

    always_comb begin
        active_d = active_q;
        y_d      = y_q;
        hit      = 1'b0;
        miss_cnt = 2'd0;
        // Judging uses the pre-update position.
        if (press) begin
            if (in_win) begin
                hit      = 1'b1;
                active_d = 1'b0;
            end else begin
                miss_cnt = 2'd1;
            end
        end
        // A hit wins over expiry on the same tick.
        if (tick && active_q && !hit) begin
            if (y_fall > WIN_HI) begin
                active_d = 1'b0;
                miss_cnt = miss_cnt + 2'd1;
            end else begin
                y_d = y_fall[10:0];
            end
        end
        // Spawns only land in lanes that were empty at the start of the cycle.
        if (spawn && !active_q) begin
            active_d = 1'b1;
            y_d      = 11'd0;
        end
    end
endmodule

module ddr_game_ctrl #(
    parameter int         SPAWN_DIV  = 30,
    parameter int         SPEED      = 2,
    parameter int         HIT_Y      = 400,
    parameter int         HIT_WIN    = 16,
    parameter int         MAX_SCORE  = 9999,
    parameter int         MISS_LIMIT = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    output logic [3:0]  lane_active,
    output logic [43:0] lane_y,
    output logic [15:0] score,
    output logic [3:0]  misses,
    output logic [1:0]  state,
    output logic        game_over
);
    localparam int CNT_W = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [15:0]       score_q, score_d;
    logic [3:0]        misses_q, misses_d;
    logic [3:0]        lane_active_q, lane_active_d;
    logic [3:0][10:0]  lane_y_q, lane_y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [3:0]        hist_q, hist_d;
    logic              game_over_q, game_over_d;

    logic [3:0]        btn_now, press, spawn_vec;
    logic [7:0]        lfsr_nxt;
    logic              spawn_fire;
    logic [3:0]        lane_act_nx, lane_hit;
    logic [3:0][10:0]  lane_y_nx;
    logic [3:0][1:0]   lane_miss;
    logic [2:0]        hit_sum;
    logic [3:0]        miss_sum;
    logic [16:0]       score_sum;
    logic [4:0]        misses_sum;

    assign btn_now    = {btn_r, btn_l, btn_d, btn_u};
    assign press      = btn_now & ~hist_q;
    assign lfsr_nxt   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign spawn_fire = (state_q == PLAY) && frame_tick && (cnt_q == CNT_W'(SPAWN_DIV - 1));
    // Target lane comes from the freshly stepped LFSR value.
    assign spawn_vec  = spawn_fire ? (4'b0001 << lfsr_nxt[1:0]) : 4'b0000;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        ddr_lane #(.SPEED(SPEED), .HIT_Y(HIT_Y), .HIT_WIN(HIT_WIN)) u_lane (
            .active_q (lane_active_q[k]),
            .y_q      (lane_y_q[k]),
            .press    (press[k]),
            .tick     (frame_tick),
            .spawn    (spawn_vec[k]),
            .active_d (lane_act_nx[k]),
            .y_d      (lane_y_nx[k]),
            .hit      (lane_hit[k]),
            .miss_cnt (lane_miss[k])
        );
    end

    always_comb begin
        hit_sum  = 3'd0;
        miss_sum = 4'd0;
        for (int k = 0; k < 4; k++) begin
            hit_sum  = hit_sum + 3'(lane_hit[k]);
            miss_sum = miss_sum + 4'(lane_miss[k]);
        end
    end

    assign score_sum  = 17'(score_q) + 17'(hit_sum);
    assign misses_sum = 5'(misses_q) + 5'(miss_sum);

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        misses_d      = misses_q;
        lane_active_d = lane_active_q;
        lane_y_d      = lane_y_q;
        cnt_d         = cnt_q;
        lfsr_d        = lfsr_q;
        hist_d        = btn_now;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = PLAY;
                    score_d       = 16'd0;
                    misses_d      = 4'd0;
                    lane_active_d = 4'd0;
                    lane_y_d      = '0;
                    cnt_d         = '0;
                    lfsr_d        = LFSR_SEED;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (spawn_fire) begin
                        cnt_d  = '0;
                        lfsr_d = lfsr_nxt;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                lane_active_d = lane_act_nx;
                lane_y_d      = lane_y_nx;
                score_d  = (score_sum > 17'(MAX_SCORE)) ? 16'(MAX_SCORE) : score_sum[15:0];
                misses_d = (misses_sum >= 5'(MISS_LIMIT)) ? 4'(MISS_LIMIT) : misses_sum[3:0];
                if (misses_d == 4'(MISS_LIMIT)) state_d = OVER;
            end
            OVER: begin
                if (start) begin
                    state_d       = IDLE;
                    lane_active_d = 4'd0;
                    lane_y_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            score_q       <= 16'd0;
            misses_q      <= 4'd0;
            lane_active_q <= 4'd0;
            lane_y_q      <= '0;
            cnt_q         <= '0;
            lfsr_q        <= LFSR_SEED;
            hist_q        <= 4'd0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            misses_q      <= misses_d;
            lane_active_q <= lane_active_d;
            lane_y_q      <= lane_y_d;
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
            hist_q        <= hist_d;
            game_over_q   <= game_over_d;
        end
    end

    assign lane_active = lane_active_q;
    assign lane_y      = lane_y_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign state       = state_q;
    assign game_over   = game_over_q;
endmodule

// File: tb/tb_ddr_game_ctrl.sv
// Bench for ddr_game_ctrl: directed walk through a round followed by random
// play, compared every cycle against a lane/score model kept here.
module tb_ddr_game_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0, start = 1'b0;
    logic        btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic [3:0]  lane_active, lane_active2, misses, misses2;
    logic [43:0] lane_y, lane_y2;
    logic [15:0] score, score2;
    logic [1:0]  state, state2;
    logic        game_over, game_over2;

    always #5 clk = ~clk;

    ddr_game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .lane_active(lane_active), .lane_y(lane_y), .score(score),
        .misses(misses), .state(state), .game_over(game_over)
    );

    // Same stimulus, score saturating at 2.
    ddr_game_ctrl #(.MAX_SCORE(2)) dut2 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .lane_active(lane_active2), .lane_y(lane_y2), .score(score2),
        .misses(misses2), .state(state2), .game_over(game_over2)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: game rules with plain integers.
    int m_state, m_score, m_score2, m_miss, m_cnt, m_lfsr;
    int m_act[4], m_y[4], m_prev[4];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_score2 = 0; m_miss = 0; m_cnt = 0; m_lfsr = 'hA5;
        for (int k = 0; k < 4; k++) begin m_act[k] = 0; m_y[k] = 0; m_prev[k] = 0; end
    endtask

    task automatic model_step(input bit tick, input bit st, input bit [3:0] b);
        int pr[4];
        int old_act[4];
        int hits, ms, spawn_lane, fb;
        bit inwin;
        for (int k = 0; k < 4; k++) begin
            pr[k] = (b[k] && m_prev[k] == 0) ? 1 : 0;
            m_prev[k] = b[k];
        end
        if (m_state == 0) begin
            if (st) begin
                m_state = 1; m_score = 0; m_score2 = 0; m_miss = 0; m_cnt = 0; m_lfsr = 'hA5;
                for (int k = 0; k < 4; k++) begin m_act[k] = 0; m_y[k] = 0; end
            end
        end else if (m_state == 2) begin
            if (st) begin
                m_state = 0;
                for (int k = 0; k < 4; k++) begin m_act[k] = 0; m_y[k] = 0; end
            end
        end else begin
            hits = 0; ms = 0; spawn_lane = -1;
            if (tick) begin
                if (m_cnt == 29) begin
                    m_cnt = 0;
                    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
                    m_lfsr = ((m_lfsr * 2) % 256) + fb;
                    spawn_lane = m_lfsr % 4;
                end else m_cnt++;
            end
            for (int k = 0; k < 4; k++) old_act[k] = m_act[k];
            for (int k = 0; k < 4; k++) begin
                inwin = old_act[k] != 0 && m_y[k] >= 384 && m_y[k] <= 416;
                if (pr[k] != 0) begin
                    if (inwin) begin hits++; m_act[k] = 0; end
                    else ms++;
                end
                if (tick && old_act[k] != 0 && !(pr[k] != 0 && inwin)) begin
                    if (m_y[k] + 2 > 416) begin m_act[k] = 0; ms++; end
                    else m_y[k] += 2;
                end
            end
            if (spawn_lane >= 0 && old_act[spawn_lane] == 0) begin
                m_act[spawn_lane] = 1; m_y[spawn_lane] = 0;
            end
            m_score  = (m_score + hits > 9999) ? 9999 : m_score + hits;
            m_score2 = (m_score2 + hits > 2) ? 2 : m_score2 + hits;
            m_miss   = (m_miss + ms > 8) ? 8 : m_miss + ms;
            if (m_miss == 8) m_state = 2;
        end
    endtask

    task automatic check_all();
        int ev;
        ev = 0;
        for (int k = 0; k < 4; k++) ev += m_act[k] << k;
        chk("state", state, m_state);
        chk("game_over", game_over, (m_state == 2) ? 1 : 0);
        chk("score", score, m_score);
        chk("misses", misses, m_miss);
        chk("lane_active", lane_active, ev);
        for (int k = 0; k < 4; k++)
            if (m_act[k] != 0) chk("lane_y", lane_y[11*k +: 11], m_y[k]);
        chk("score_sat2", score2, m_score2);
        chk("state_sat2", state2, m_state);
    endtask

    task automatic cyc(input bit tick, input bit st, input bit [3:0] b);
        frame_tick = tick; start = st;
        {btn_r, btn_l, btn_d, btn_u} = b;
        model_step(tick, st, b);
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        {btn_r, btn_l, btn_d, btn_u} = 4'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_lanes", lane_active, 0);
        chk("rst_lane_y", int'(lane_y == 44'd0), 1);
        chk("rst_game_over", game_over, 0);
    endtask

    bit [3:0] rb;

    initial begin
        model_reset();
        do_reset();
        // IDLE ignores ticks and presses.
        cyc(1, 0, 4'b1111); cyc(1, 0, 4'b0000);
        cyc(0, 1, 4'b0000);
        chk("enter_play", state, 1);
        // First spawn on the 30th tick lands in lane 2.
        for (int i = 0; i < 30; i++) cyc(1, 0, 4'b0000);
        chk("spawn1_lanes", lane_active, 4'b0100);
        chk("spawn1_y", lane_y[32:22], 0);
        for (int i = 0; i < 30; i++) cyc(1, 0, 4'b0000);
        chk("spawn2_lanes", lane_active, 4'b0110);
        // 192 ticks after the lane-2 spawn, y=384: press left.
        for (int i = 0; i < 162; i++) cyc(1, 0, 4'b0000);
        chk("lane2_y384", lane_y[32:22], 384);
        cyc(0, 0, 4'b0100);
        chk("hit_score", score, 1);
        chk("hit_clear", lane_active[2], 0);
        chk("hit_nomiss", misses, 0);
        cyc(0, 0, 4'b0000);
        // Press into an empty lane; holding counts once.
        cyc(0, 0, 4'b0100);
        chk("empty_press", misses, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'b0100);
        chk("held_press", misses, 1);
        cyc(0, 0, 4'b0000);
        // Lane 1 (spawned on tick 60) reaches 416 then expires.
        for (int i = 0; i < 46; i++) cyc(1, 0, 4'b0000);
        chk("lane1_y416", lane_y[21:11], 416);
        chk("lane1_alive", lane_active[1], 1);
        cyc(1, 0, 4'b0000);
        chk("expire_clear", lane_active[1], 0);
        chk("expire_miss", misses, 2);
        // Lane 0 (spawned on tick 120): hit coincident with the expiry tick.
        for (int i = 0; i < 59; i++) cyc(1, 0, 4'b0000);
        chk("lane0_y416", lane_y[10:0], 416);
        cyc(1, 0, 4'b0001);
        chk("edge_hit_score", score, 2);
        chk("edge_hit_nomiss", misses, 2);
        cyc(0, 0, 4'b0000);
        // Third hit: main score 3, saturating instance stays at 2.
        for (int i = 0; i < 400 && !(m_act[2] != 0 && m_y[2] == 384); i++) cyc(1, 0, 4'b0000);
        chk("lane2_reach384", lane_y[32:22], 384);
        cyc(0, 0, 4'b0100);
        chk("hit3_score", score, 3);
        chk("hit3_sat", score2, 2);
        cyc(0, 0, 4'b0000);
        // Wrong presses until the round ends.
        for (int i = 0; i < 10 && m_state != 2; i++) begin
            cyc(0, 0, 4'b0100);
            cyc(0, 0, 4'b0000);
        end
        chk("over_state", state, 2);
        chk("over_flag", game_over, 1);
        chk("over_score", score, 3);
        chk("over_misses", misses, 8);
        // OVER is frozen.
        cyc(1, 0, 4'b1111); cyc(1, 0, 4'b0000); cyc(1, 0, 4'b1010);
        chk("frozen_score", score, 3);
        chk("frozen_misses", misses, 8);
        cyc(0, 1, 4'b0000);
        chk("to_idle", state, 0);
        chk("idle_lanes", lane_active, 0);
        cyc(0, 1, 4'b0000);
        chk("replay_state", state, 1);
        chk("replay_score", score, 0);
        chk("replay_misses", misses, 0);
        // Random play with occasional starts and resets.
        rb = 4'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
                rb = 4'b0;
            end else begin
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(7) == 0) rb[k] = ~rb[k];
                cyc(bit'($urandom_range(1)), ($urandom_range(49) == 0), rb);
            end
        end
        // Reset in the middle of a round.
        do_reset();
        cyc(0, 1, 4'b0000);
        for (int i = 0; i < 40; i++) cyc(1, 0, 4'b0000);
        chk("midround_lanes", lane_active, 4'b0100);
        do_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
